// File: rtl/regfile_pkg.sv
// Shared types and default dimensions for the register-file write arbiter.
// The FSM encoding is fixed so debug probes can decode the state directly.
package regfile_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// the pointer, wrapping modulo NREQ, gets a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_any                               = 1'b1;
                o_grant[(int'(i_ptr) + k) % NREQ]   = 1'b1;
                o_idx                               = PW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NREQ requesters and
// runs a one-register-per-cycle clear sweep on request.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic               i_clr_start,
    output logic               o_clr_busy,
    output logic               o_clr_done,
    output logic               o_wr_en,
    output logic [AW-1:0]      o_wr_addr,
    output logic [DW-1:0]      o_wr_data,
    output logic [AW-1:0]      o_grant_id
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [AW-1:0]   r_cnt;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [AW-1:0]   r_grant_id;
    logic            r_clr_busy;
    logic            r_clr_done;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic            w_arb_en;
    logic            w_accept;
    logic [PW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A clear request in the same cycle pre-empts any grant.
    assign w_arb_en    = (r_state == ST_IDLE) && !i_clr_start && !i_rst;
    assign w_accept    = w_arb_en && w_any;
    assign o_req_ready = w_arb_en ? w_grant : '0;
    assign w_ptr_next  = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = i_req_addr[i*AW +: AW];
                w_sel_data = i_req_data[i*DW +: DW];
            end
        end
    end

    // The first sweep write is issued on the clr_start edge itself, so busy
    // covers exactly the DEPTH cycles in which sweep writes are on the port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_clr_start) begin
                        r_state    <= ST_CLEAR;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= '0;
                        r_wr_data  <= '0;
                        r_cnt      <= AW'(1);
                        r_clr_busy <= 1'b1;
                    end else if (w_accept) begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= w_sel_addr;
                        r_wr_data  <= w_sel_data;
                        r_grant_id <= AW'(w_idx);
                        r_ptr      <= w_ptr_next;
                    end else begin
                        r_wr_en    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_cnt;
                    r_wr_data <= '0;
                    r_cnt     <= r_cnt + AW'(1);
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_wr_en    <= 1'b0;
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_en    <= 1'b0;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_grant_id = r_grant_id;
    assign o_clr_busy = r_clr_busy;
    assign o_clr_done = r_clr_done;

endmodule
